// File: rtl/uart_rx_fsm.sv
// UART receive sequencer: walks IDLE/START/DATA/PARITY/STOP at the oversample rate and strobes the bit checkers.
// Latency: every output is registered; frame verdict (data_valid/frame_err) lands on the first IDLE cycle after STOP.
// Backpressure: none; the serial line cannot be stalled, so the FSM free-runs once a start edge is seen.
//
// Ports:
//   CLK, RST          oversample clock, asynchronous active-high reset
//   RX_IN             serial line (idle high); only looked at while IDLE
//   PAR_EN            frame carries a parity bit (looked at on the last data bit end)
//   Prescale          oversampling ratio 8/16/32 (anything else behaves as 8), captured at start
//   par_error, strt_glitch, stp_err   registered verdicts from the bit checkers
//   data_samp_en      bit sampler enable, high whenever a frame is in progress
//   edge_cnt, bit_cnt oversample position within the bit / data bit index
//   deser_en, Sample_Available        shift + parity-accumulate strobes at each data bit sample point
//   RST_parity        active-low clear of the parity accumulator, low while IDLE
//   strt_chk_en, par_check_en, stp_chk_en   one-cycle checker strobes at the sample point
//   data_valid, frame_err             one-cycle frame verdict pulses
module uart_rx_fsm (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic [5:0] Prescale,
  input  logic       par_error,
  input  logic       strt_glitch,
  input  logic       stp_err,
  output logic       data_samp_en,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       deser_en,
  output logic       Sample_Available,
  output logic       RST_parity,
  output logic       par_check_en,
  output logic       strt_chk_en,
  output logic       stp_chk_en,
  output logic       data_valid,
  output logic       frame_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0] state, state_n;
  logic [5:0] p_reg, p_n;
  logic [5:0] edge_n;
  logic [3:0] bit_n;
  logic [5:0] samp_pt;
  logic       err, err_n;
  logic       dv_n, fe_n;
  logic       wrap;

  // Unsupported ratios fall back to 8 so a bad Prescale still yields a sane bit timing.
  function automatic logic [5:0] decode_p(input logic [5:0] ps);
    case (ps)
      6'd16:   decode_p = 6'd16;
      6'd32:   decode_p = 6'd32;
      default: decode_p = 6'd8;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    p_n     = p_reg;
    edge_n  = edge_cnt;
    bit_n   = bit_cnt;
    err_n   = err;
    dv_n    = 1'b0;
    fe_n    = 1'b0;
    wrap    = (edge_cnt == (p_reg - 6'd1));

    if (state == IDLE) begin
      edge_n = 6'd0;
      bit_n  = 4'd0;
      // The IDLE cycle that sees the low level counts as oversample 0 of the start bit.
      if (!RX_IN) begin
        state_n = START;
        edge_n  = 6'd1;
        p_n     = decode_p(Prescale);
      end
    end else begin
      edge_n = wrap ? 6'd0 : (edge_cnt + 6'd1);
      if (wrap) begin
        case (state)
          START: begin
            if (strt_glitch) begin
              state_n = IDLE;
            end else begin
              state_n = DATA;
              bit_n   = 4'd0;
            end
          end
          DATA: begin
            if (bit_cnt == 4'd7) begin
              bit_n   = 4'd0;
              state_n = PAR_EN ? PARITY : STOP;
            end else begin
              bit_n = bit_cnt + 4'd1;
            end
          end
          PARITY: begin
            err_n   = par_error;
            state_n = STOP;
          end
          STOP: begin
            dv_n    = !stp_err && !err;
            fe_n    = stp_err || err;
            err_n   = 1'b0;
            state_n = IDLE;
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // Mid-bit sample point, P/2+2, taken from the ratio in force next cycle so
  // the very first START cycle already uses the freshly captured value.
  assign samp_pt = (p_n >> 1) + 6'd2;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state            <= IDLE;
      p_reg            <= 6'd8;
      err              <= 1'b0;
      edge_cnt         <= 6'd0;
      bit_cnt          <= 4'd0;
      data_samp_en     <= 1'b0;
      RST_parity       <= 1'b0;
      deser_en         <= 1'b0;
      Sample_Available <= 1'b0;
      strt_chk_en      <= 1'b0;
      par_check_en     <= 1'b0;
      stp_chk_en       <= 1'b0;
      data_valid       <= 1'b0;
      frame_err        <= 1'b0;
    end else begin
      state            <= state_n;
      p_reg            <= p_n;
      err              <= err_n;
      edge_cnt         <= edge_n;
      bit_cnt          <= bit_n;
      // Strobes are decoded from next-state values so they line up with the
      // registered edge_cnt showing the sample point.
      data_samp_en     <= (state_n != IDLE);
      RST_parity       <= (state_n != IDLE);
      deser_en         <= (state_n == DATA)   && (edge_n == samp_pt);
      Sample_Available <= (state_n == DATA)   && (edge_n == samp_pt);
      strt_chk_en      <= (state_n == START)  && (edge_n == samp_pt);
      par_check_en     <= (state_n == PARITY) && (edge_n == samp_pt);
      stp_chk_en       <= (state_n == STOP)   && (edge_n == samp_pt);
      data_valid       <= dv_n;
      frame_err        <= fe_n;
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
module tb_uart_rx_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic       par_error = 1'b0;
  logic       strt_glitch = 1'b0;
  logic       stp_err = 1'b0;
  logic       data_samp_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       deser_en, Sample_Available, RST_parity, par_check_en;
  logic       strt_chk_en, stp_chk_en, data_valid, frame_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int deser, strt, par, stp, dv, fe, end_cyc, rstp, bad;
  } res_t;

  res_t exp_q[$];
  int   cyc_q[$];

  uart_rx_fsm dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
    .par_error(par_error), .strt_glitch(strt_glitch), .stp_err(stp_err),
    .data_samp_en(data_samp_en), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .deser_en(deser_en), .Sample_Available(Sample_Available), .RST_parity(RST_parity),
    .par_check_en(par_check_en), .strt_chk_en(strt_chk_en), .stp_chk_en(stp_chk_en),
    .data_valid(data_valid), .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  function automatic int peff(input logic [5:0] ps);
    if (ps == 6'd16) return 16;
    if (ps == 6'd32) return 32;
    return 8;
  endfunction

  function automatic logic [18:0] all_outs();
    return {data_samp_en, edge_cnt, bit_cnt, deser_en, Sample_Available, RST_parity,
            par_check_en, strt_chk_en, stp_chk_en, data_valid, frame_err};
  endfunction

  // Drives one frame on the line and records what the DUT did until it is back in IDLE.
  task automatic drive_frame(input logic [5:0] ps, input logic pe, input logic [7:0] b,
                             input logic g, input logic perr, input logic serr, output res_t o);
    int p, s, bi;
    logic bits [0:10];
    p = peff(ps);
    s = p / 2 + 2;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    bits[9]  = pe ? ^b : 1'b1;
    bits[10] = 1'b1;
    o = '{default: 0};
    o.end_cyc = -1;
    @(posedge CLK); #1;
    Prescale = ps; PAR_EN = pe; strt_glitch = g; par_error = perr; stp_err = serr;
    RX_IN = 1'b0;
    for (int c = 1; c <= 12 * p + 4; c++) begin
      @(posedge CLK); #1;
      bi = c / p;
      RX_IN = (bi <= 10) ? bits[bi] : 1'b1;
      @(negedge CLK);
      if (deser_en) begin
        if (edge_cnt != s[5:0] || bit_cnt != o.deser[3:0]) o.bad++;
        o.deser++;
      end
      if (deser_en != Sample_Available) o.bad++;
      if (strt_chk_en) begin o.strt++; if (edge_cnt != s[5:0]) o.bad++; end
      if (par_check_en) begin o.par++; if (edge_cnt != s[5:0]) o.bad++; end
      if (stp_chk_en) begin o.stp++; if (edge_cnt != s[5:0]) o.bad++; end
      if (data_valid) o.dv++;
      if (frame_err) o.fe++;
      if (data_valid && frame_err) o.bad++;
      if (!data_samp_en) begin
        RX_IN = 1'b1;
        o.end_cyc = c;
        o.rstp = RST_parity;
        break;
      end
    end
    RX_IN = 1'b1;
  endtask

  task automatic test_frame(input string name, input logic [5:0] ps, input logic pe,
                            input logic [7:0] b, input logic g, input logic perr, input logic serr);
    res_t e, o;
    int p;
    p = peff(ps);
    e = '{default: 0};
    e.strt = 1;
    if (g) begin
      e.end_cyc = p;
    end else begin
      e.deser   = 8;
      e.par     = pe ? 1 : 0;
      e.stp     = 1;
      e.dv      = (!(pe && perr) && !serr) ? 1 : 0;
      e.fe      = 1 - e.dv;
      e.end_cyc = (pe ? 11 : 10) * p;
    end
    exp_q.push_back(e);
    drive_frame(ps, pe, b, g, perr, serr, o);
    e = exp_q.pop_front();
    checks++; if (o.deser !== e.deser) begin failures++; $display("FAIL %s deser_cnt got %0d want %0d", name, o.deser, e.deser); end
    checks++; if (o.strt !== e.strt) begin failures++; $display("FAIL %s strt_chk_cnt got %0d want %0d", name, o.strt, e.strt); end
    checks++; if (o.par !== e.par) begin failures++; $display("FAIL %s par_chk_cnt got %0d want %0d", name, o.par, e.par); end
    checks++; if (o.stp !== e.stp) begin failures++; $display("FAIL %s stp_chk_cnt got %0d want %0d", name, o.stp, e.stp); end
    checks++; if (o.dv !== e.dv) begin failures++; $display("FAIL %s data_valid_cnt got %0d want %0d", name, o.dv, e.dv); end
    checks++; if (o.fe !== e.fe) begin failures++; $display("FAIL %s frame_err_cnt got %0d want %0d", name, o.fe, e.fe); end
    checks++; if (o.end_cyc !== e.end_cyc) begin failures++; $display("FAIL %s end_cycle got %0d want %0d", name, o.end_cyc, e.end_cyc); end
    checks++; if (o.rstp !== e.rstp) begin failures++; $display("FAIL %s RST_parity_at_idle got %0d want %0d", name, o.rstp, e.rstp); end
    checks++; if (o.bad !== e.bad) begin failures++; $display("FAIL %s strobe_position_errors got %0d want %0d", name, o.bad, e.bad); end
  endtask

  task automatic test_reset();
    int busy;
    RST = 1'b1; RX_IN = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++; if (all_outs() !== 19'd0) begin failures++; $display("FAIL reset_outputs got %h want 0", all_outs()); end
    @(posedge CLK); #1; RST = 1'b0;
    busy = 0;
    repeat (5) begin @(negedge CLK); if (data_samp_en || edge_cnt != 0 || bit_cnt != 0) busy++; end
    checks++; if (busy !== 0) begin failures++; $display("FAIL idle_after_reset busy_cycles got %0d want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int n, c;
    @(posedge CLK); #1;
    Prescale = 6'd32; PAR_EN = 1'b0; strt_glitch = 1'b0; par_error = 1'b0; stp_err = 1'b0;
    cyc_q.push_back(320);
    cyc_q.push_back(640);
    RX_IN = 1'b0;   // held low so the first IDLE cycle after STOP starts the next frame
    n = 0;
    for (c = 1; c <= 700; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (frame_err) begin failures++; checks++; $display("FAIL b2b frame_err got 1 want 0 at cycle %0d", c); end
      if (data_valid) begin
        checks++;
        if (cyc_q.size() == 0) begin failures++; $display("FAIL b2b extra_data_valid at cycle %0d", c); end
        else begin
          int w;
          w = cyc_q.pop_front();
          if (c !== w) begin failures++; $display("FAIL b2b data_valid_cycle got %0d want %0d", c, w); end
        end
        n++;
        if (n == 2) begin RX_IN = 1'b1; break; end
      end
    end
    checks++; if (cyc_q.size() !== 0) begin failures++; $display("FAIL b2b missing_data_valid got %0d outstanding want 0", cyc_q.size()); cyc_q.delete(); end
    @(negedge CLK);
    checks++; if (data_samp_en !== 1'b0) begin failures++; $display("FAIL b2b idle_after got %b want 0", data_samp_en); end
  endtask

  task automatic test_reset_mid_frame();
    int found, pulses, busy;
    @(posedge CLK); #1;
    Prescale = 6'd8; PAR_EN = 1'b0; strt_glitch = 1'b0; stp_err = 1'b0; par_error = 1'b0;
    RX_IN = 1'b0;
    @(posedge CLK); #1; RX_IN = 1'b1;
    found = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (deser_en && bit_cnt == 4'd4) begin found = 1; break; end
    end
    checks++; if (found !== 1) begin failures++; $display("FAIL rst_mid reach_bit4 got %0d want 1", found); end
    #2 RST = 1'b1;
    #1;
    checks++; if (all_outs() !== 19'd0) begin failures++; $display("FAIL rst_mid outputs got %h want 0", all_outs()); end
    pulses = 0;
    repeat (3) begin @(negedge CLK); if (data_valid || frame_err || deser_en) pulses++; end
    @(posedge CLK); #1; RST = 1'b0;
    busy = 0;
    repeat (6) begin @(negedge CLK); if (data_valid || frame_err) pulses++; if (data_samp_en) busy++; end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL rst_mid pulses got %0d want 0", pulses); end
    checks++; if (busy !== 0) begin failures++; $display("FAIL rst_mid left_idle got %0d want 0", busy); end
    test_frame("after_rst", 6'd8, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_frame("p8_a5",        6'd8,  1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    test_frame("p16_par_err",  6'd16, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
    test_frame("p16_par_ok",   6'd16, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    test_frame("p8_stop_err",  6'd8,  1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
    test_frame("p16_glitch",   6'd16, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    test_frame("p12_as_8",     6'd12, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
    test_frame("p32_noparerr", 6'd32, 1'b0, 8'h7E, 1'b0, 1'b1, 1'b0);
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 SHALL have ports, clock and reset first:
- CLK  in  1  single receive clock, oversampling rate; all state on rising edge.
- RST  in  1  reset: asynchronous, active-high; asserted forces reset state immediately.
- RX_IN  in  1  serial line; idle high, start bit low.
- PAR_EN  in  1  1 = frame carries a parity bit.
- Prescale  in  6  oversampling ratio; legal 8, 16, 32.
- par_error  in  1  registered result from parity checker.
- strt_glitch  in  1  registered result from start checker; 1 = false start.
- stp_err  in  1  registered result from stop checker.
- data_samp_en  out  1  enables the bit sampler.
- edge_cnt  out  6  oversample position within the current bit.
- bit_cnt  out  4  data bit index, 0..7.
- deser_en  out  1  one-cycle shift strobe to the deserializer.
- Sample_Available  out  1  one-cycle parity accumulate strobe.
- RST_parity  out  1  active-low synchronous clear of the parity accumulator.
- par_check_en  out  1  one-cycle parity compare strobe.
- strt_chk_en  out  1  one-cycle start check strobe.
- stp_chk_en  out  1  one-cycle stop check strobe.
- data_valid  out  1  one-cycle frame-good pulse.
- frame_err  out  1  one-cycle frame-error pulse.
REQ-002 All outputs SHALL be registered.

Function
REQ-003 States SHALL be IDLE, START, DATA, PARITY and STOP, with a binary encoding.
REQ-004 Prescale SHALL be captured as P on the IDLE->START transition; any value other than 16 or 32 SHALL be treated as 8.
REQ-005 Sample point S SHALL equal P/2+2: 6, 10 or 18.
REQ-006 Start detection:
- In IDLE with RX_IN=0, next state SHALL be START with edge_cnt=1.
- In IDLE, edge_cnt=0 and bit_cnt=0.
REQ-007 Outside IDLE, edge_cnt SHALL increment each cycle and wrap from P-1 to 0; the wrap cycle is the bit end.
REQ-008 data_samp_en SHALL equal 1 in every state except IDLE.
REQ-009 START:
- strt_chk_en pulses at edge_cnt=S.
- At bit end: strt_glitch=1 -> IDLE; else -> DATA with bit_cnt=0.
REQ-010 DATA:
- deser_en and Sample_Available pulse together at edge_cnt=S.
- At bit end, bit_cnt increments.
- At bit end with bit_cnt=7: -> PARITY if PAR_EN=1, else -> STOP; bit_cnt returns to 0.
REQ-011 PARITY:
- par_check_en pulses at edge_cnt=S.
- At bit end, par_error is latched into an internal error flag; -> STOP.
REQ-012 STOP:
- stp_chk_en pulses at edge_cnt=S.
- At bit end: if stp_err=0 and the flag is clear, data_valid pulses; otherwise frame_err pulses.
- Then -> IDLE and the flag clears.
REQ-013 RST_parity SHALL be 0 in IDLE and 1 in all other states, clearing the accumulator before every frame.
REQ-014 data_valid and frame_err SHALL never both be 1.
REQ-015 PAR_EN SHALL be sampled at the DATA->next transition only.
REQ-016 Back-to-back frames: RX_IN=0 on the first IDLE cycle after STOP SHALL start a new frame with no lost cycle.
REQ-017 RX_IN changes outside IDLE SHALL NOT alter state; only the checker results steer transitions.

Reset
REQ-018 RST=1 SHALL asynchronously force:
- state IDLE; edge_cnt 0; bit_cnt 0; error flag 0.
- All strobes and data_samp_en 0; RST_parity 0.
REQ-019 RST asserted mid-frame SHALL abort the frame with no data_valid or frame_err pulse.
REQ-020 After RST deasserts, the block SHALL require RX_IN=0 in IDLE before leaving IDLE.

Verification
REQ-021 Prescale=8, PAR_EN=0, byte 0xA5, clean checkers -> 8 deser_en pulses at edge_cnt=6; data_valid pulses once, 80 cycles after the falling edge.
REQ-022 Prescale=16, PAR_EN=1, par_error=1 at the parity bit end -> frame_err pulses once; data_valid stays 0; then IDLE.
REQ-023 strt_glitch=1 at the START bit end -> return to IDLE; no deser_en pulses; RST_parity=0 the next cycle.
REQ-024 Prescale=32, two back-to-back frames with RX_IN=0 on the first IDLE cycle -> two data_valid pulses 320 cycles apart.
REQ-025 RST asserted during DATA with bit_cnt=4 -> all outputs 0 in the same cycle; no pulses; the next frame is received correctly.
REQ-026 Prescale=12 -> behaves as 8: S=6, bit length 8 cycles.
